// File: rtl/hbm_wt_pkg.sv
// Shared types and geometry helpers for the HBM weight/scale splitter.
package hbm_wt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WT    = 2'd1,
        SCALE = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Beats per full group: GROUP_CH weights of WT_DW bits packed into HBM_DW-bit beats.
    function automatic int unsigned calc_bpg(input int unsigned group_ch,
                                             input int unsigned wt_dw,
                                             input int unsigned hbm_dw);
        return (group_ch * wt_dw) / hbm_dw;
    endfunction

    // Quant scales carried by the scale word of a full group.
    function automatic int unsigned calc_spg(input int unsigned group_ch,
                                             input int unsigned qblock);
        return group_ch / qblock;
    endfunction

    // Width of the scale_cnt field (must be able to hold calc_spg itself).
    function automatic int unsigned scale_cnt_w(input int unsigned group_ch,
                                                input int unsigned qblock);
        return $clog2(group_ch / qblock) + 1;
    endfunction

endpackage

// File: rtl/wt_scale_cnt_gen.sv
// Config latch and beat/group/row counters for the weight/scale splitter.
// Produces the per-beat limit flag, last-group/last-row flags and the scale
// count of the group currently being parsed.
module wt_scale_cnt_gen
    import hbm_wt_pkg::*;
#(
    parameter int unsigned HBM_DW   = 256,
    parameter int unsigned WT_DW    = 4,
    parameter int unsigned GROUP_CH = 2048,
    parameter int unsigned QBLOCK   = 128,
    parameter int unsigned CFG_W    = 16
)(
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_load,
    input  logic [CFG_W-1:0]                         i_cfg_chin,
    input  logic [CFG_W-1:0]                         i_cfg_rows,
    input  logic                                     i_beat_inc,
    input  logic                                     i_group_inc,
    output logic                                     o_cfg_empty,
    output logic                                     o_at_limit,
    output logic                                     o_last_group,
    output logic                                     o_last_row,
    output logic [scale_cnt_w(GROUP_CH, QBLOCK)-1:0] o_scale_cnt
);

    localparam int unsigned BPG = calc_bpg(GROUP_CH, WT_DW, HBM_DW);
    localparam int unsigned SPG = calc_spg(GROUP_CH, QBLOCK);
    localparam int unsigned SCW = scale_cnt_w(GROUP_CH, QBLOCK);

    logic [CFG_W-1:0] w_n_full;
    logic [CFG_W-1:0] w_last_ch;
    logic [CFG_W-1:0] w_last_beats;
    logic [SCW-1:0]   w_part_scl;
    logic             w_has_part;

    logic [CFG_W-1:0] r_n_full;
    logic [CFG_W-1:0] r_n_groups;
    logic [CFG_W-1:0] r_last_beats;
    logic [SCW-1:0]   r_part_scl;
    logic             r_has_part;
    logic [CFG_W-1:0] r_rows;
    logic [CFG_W-1:0] r_beat_cnt;
    logic [CFG_W-1:0] r_grp_cnt;
    logic [CFG_W-1:0] r_row_cnt;

    logic             w_partial;
    logic [CFG_W-1:0] w_limit;

    // Derive group geometry from the raw config so it can be latched at start.
    always_comb begin
        w_n_full     = CFG_W'(32'(i_cfg_chin) / GROUP_CH);
        w_last_ch    = CFG_W'(32'(i_cfg_chin) % GROUP_CH);
        w_last_beats = CFG_W'((32'(w_last_ch) * WT_DW) / HBM_DW);
        w_part_scl   = SCW'((32'(w_last_ch) + QBLOCK - 1) / QBLOCK);
        w_has_part   = (w_last_ch != '0);
    end

    assign o_cfg_empty = (i_cfg_chin == '0) || (i_cfg_rows == '0);

    // Per-group limit and boundary flags from the latched geometry.
    always_comb begin
        w_partial    = r_has_part && (r_grp_cnt == r_n_full);
        w_limit      = w_partial ? r_last_beats : CFG_W'(BPG);
        o_at_limit   = ((r_beat_cnt + CFG_W'(1)) == w_limit);
        o_last_group = (r_grp_cnt == (r_n_groups - CFG_W'(1)));
        o_last_row   = (r_row_cnt == (r_rows - CFG_W'(1)));
        o_scale_cnt  = w_partial ? r_part_scl : SCW'(SPG);
    end

    // Latch config on load; step beat/group/row counters on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n_full     <= '0;
            r_n_groups   <= '0;
            r_last_beats <= '0;
            r_part_scl   <= '0;
            r_has_part   <= 1'b0;
            r_rows       <= '0;
            r_beat_cnt   <= '0;
            r_grp_cnt    <= '0;
            r_row_cnt    <= '0;
        end else if (i_load) begin
            r_n_full     <= w_n_full;
            r_n_groups   <= w_n_full + {{(CFG_W-1){1'b0}}, w_has_part};
            r_last_beats <= w_last_beats;
            r_part_scl   <= w_part_scl;
            r_has_part   <= w_has_part;
            r_rows       <= i_cfg_rows;
            r_beat_cnt   <= '0;
            r_grp_cnt    <= '0;
            r_row_cnt    <= '0;
        end else begin
            if (i_beat_inc) begin
                r_beat_cnt <= o_at_limit ? '0 : r_beat_cnt + CFG_W'(1);
            end
            if (i_group_inc) begin
                if (o_last_group) begin
                    r_grp_cnt <= '0;
                    r_row_cnt <= r_row_cnt + CFG_W'(1);
                end else begin
                    r_grp_cnt <= r_grp_cnt + CFG_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/hbm_wt_scale_splitter.sv
// Splits an HBM read-data stream of [weights x BPG, scale] groups into a
// zero-latency weight channel and a registered scale channel.
// Optional: define WT_STALL_PERF_EN to add the perf_stall input-stall counter.
module hbm_wt_scale_splitter
    import hbm_wt_pkg::*;
#(
    parameter int unsigned HBM_DW   = 256,
    parameter int unsigned WT_DW    = 4,
    parameter int unsigned GROUP_CH = 2048,
    parameter int unsigned QBLOCK   = 128,
    parameter int unsigned SCALE_DW = 16,
    parameter int unsigned CFG_W    = 16
)(
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [CFG_W-1:0]                         cfg_chin,
    input  logic [CFG_W-1:0]                         cfg_rows,
    output logic                                     busy,
    output logic                                     done,
    input  logic [HBM_DW-1:0]                        in_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic [HBM_DW-1:0]                        wt_data,
    output logic                                     wt_valid,
    input  logic                                     wt_ready,
    output logic                                     wt_group_last,
    output logic                                     wt_row_last,
    output logic [HBM_DW-1:0]                        scale_data,
    output logic [scale_cnt_w(GROUP_CH, QBLOCK)-1:0] scale_cnt,
    output logic                                     scale_valid,
`ifdef WT_STALL_PERF_EN
    output logic [31:0]                              perf_stall,
`endif
    input  logic                                     scale_ready
);

    localparam int unsigned SCW = scale_cnt_w(GROUP_CH, QBLOCK);

    // A group's scales must fit in one beat.
    if (calc_spg(GROUP_CH, QBLOCK) * SCALE_DW > HBM_DW) begin : g_cfg_check
        $error("scale words of one group do not fit in one HBM beat");
    end

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [HBM_DW-1:0] r_scale_data;
    logic [SCW-1:0]    r_scale_cnt;
    logic              r_scale_valid;

    logic              w_load;
    logic              w_cfg_empty;
    logic              w_at_limit;
    logic              w_last_group;
    logic              w_last_row;
    logic [SCW-1:0]    w_grp_scale_cnt;
    logic              w_scale_free;
    logic              w_in_fire;
    logic              w_wt_fire;
    logic              w_scl_fire;

    assign w_load       = start && (r_state == IDLE);
    assign w_scale_free = !r_scale_valid || scale_ready;
    assign w_in_fire    = in_valid && in_ready;
    assign w_wt_fire    = w_in_fire && (r_state == WT);
    assign w_scl_fire   = w_in_fire && (r_state == SCALE);

    wt_scale_cnt_gen #(
        .HBM_DW   (HBM_DW),
        .WT_DW    (WT_DW),
        .GROUP_CH (GROUP_CH),
        .QBLOCK   (QBLOCK),
        .CFG_W    (CFG_W)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_cfg_chin   (cfg_chin),
        .i_cfg_rows   (cfg_rows),
        .i_beat_inc   (w_wt_fire),
        .i_group_inc  (w_scl_fire),
        .o_cfg_empty  (w_cfg_empty),
        .o_at_limit   (w_at_limit),
        .o_last_group (w_last_group),
        .o_last_row   (w_last_row),
        .o_scale_cnt  (w_grp_scale_cnt)
    );

    // Route the input handshake to the weight channel or the scale register by state.
    always_comb begin
        in_ready      = 1'b0;
        wt_data       = '0;
        wt_valid      = 1'b0;
        wt_group_last = 1'b0;
        wt_row_last   = 1'b0;
        case (r_state)
            WT: begin
                wt_data       = in_data;
                wt_valid      = in_valid;
                in_ready      = wt_ready;
                wt_group_last = w_at_limit;
                wt_row_last   = w_at_limit && w_last_group;
            end
            SCALE: in_ready = w_scale_free;
            default: ;
        endcase
    end

    // Control FSM; FIN completes on the cycle the last scale drains, so done
    // and the final scale_valid drop land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_state <= w_cfg_empty ? FIN : WT;
                    end
                end
                WT: begin
                    if (w_wt_fire && w_at_limit) begin
                        r_state <= SCALE;
                    end
                end
                SCALE: begin
                    if (w_scl_fire) begin
                        r_state <= (w_last_group && w_last_row) ? FIN : WT;
                    end
                end
                default: begin
                    if (w_scale_free) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Scale word register; holds until taken, may be refilled on the draining cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scale_data  <= '0;
            r_scale_cnt   <= '0;
            r_scale_valid <= 1'b0;
        end else if (w_scl_fire) begin
            r_scale_data  <= in_data;
            r_scale_cnt   <= w_grp_scale_cnt;
            r_scale_valid <= 1'b1;
        end else if (r_scale_valid && scale_ready) begin
            r_scale_valid <= 1'b0;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign scale_data  = r_scale_data;
    assign scale_cnt   = r_scale_cnt;
    assign scale_valid = r_scale_valid;

`ifdef WT_STALL_PERF_EN
    logic [31:0] r_perf_stall;

    // Saturating count of busy cycles where offered input was not accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
        end else if (w_load) begin
            r_perf_stall <= '0;
        end else if (r_busy && in_valid && !in_ready && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_hbm_wt_scale_splitter.sv
// Randomized self-checking bench for hbm_wt_scale_splitter.
// Honours WT_STALL_PERF_EN when the design is built with it.
module tb_hbm_wt_scale_splitter;

    localparam int unsigned HBM_DW   = 256;
    localparam int unsigned WT_DW    = 4;
    localparam int unsigned GROUP_CH = 2048;
    localparam int unsigned QBLOCK   = 128;
    localparam int unsigned SCALE_DW = 16;
    localparam int unsigned CFG_W    = 16;
    localparam int unsigned SCW      = $clog2(GROUP_CH / QBLOCK) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CFG_W-1:0]  cfg_chin = '0;
    logic [CFG_W-1:0]  cfg_rows = '0;
    logic              busy;
    logic              done;
    logic [HBM_DW-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [HBM_DW-1:0] wt_data;
    logic              wt_valid;
    logic              wt_ready = 1'b0;
    logic              wt_group_last;
    logic              wt_row_last;
    logic [HBM_DW-1:0] scale_data;
    logic [SCW-1:0]    scale_cnt;
    logic              scale_valid;
    logic              scale_ready = 1'b0;
`ifdef WT_STALL_PERF_EN
    logic [31:0]       perf_stall;
`endif

    always #5 clk = ~clk;

    hbm_wt_scale_splitter #(
        .HBM_DW   (HBM_DW),
        .WT_DW    (WT_DW),
        .GROUP_CH (GROUP_CH),
        .QBLOCK   (QBLOCK),
        .SCALE_DW (SCALE_DW),
        .CFG_W    (CFG_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_chin      (cfg_chin),
        .cfg_rows      (cfg_rows),
        .busy          (busy),
        .done          (done),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wt_data       (wt_data),
        .wt_valid      (wt_valid),
        .wt_ready      (wt_ready),
        .wt_group_last (wt_group_last),
        .wt_row_last   (wt_row_last),
        .scale_data    (scale_data),
        .scale_cnt     (scale_cnt),
        .scale_valid   (scale_valid),
`ifdef WT_STALL_PERF_EN
        .perf_stall    (perf_stall),
`endif
        .scale_ready   (scale_ready)
    );

    typedef struct {
        logic [HBM_DW-1:0] d;
        logic              gl;
        logic              rl;
    } wt_exp_t;

    typedef struct {
        logic [HBM_DW-1:0] d;
        int unsigned       cnt;
    } sc_exp_t;

    logic [HBM_DW-1:0] q_in[$];
    wt_exp_t           q_wt[$];
    sc_exp_t           q_sc[$];

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check_val(input string tag, input logic [HBM_DW-1:0] got,
                             input logic [HBM_DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [HBM_DW-1:0] rand_beat();
        logic [HBM_DW-1:0] v;
        for (int i = 0; i < int'(HBM_DW / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Walk the channels of each row, carving them into groups of up to GROUP_CH.
    task automatic build_model(input int unsigned chin, input int unsigned rows);
        q_in.delete();
        q_wt.delete();
        q_sc.delete();
        for (int unsigned r = 0; r < rows; r++) begin
            int unsigned remaining = chin;
            while (remaining > 0) begin
                int unsigned gch = (remaining > GROUP_CH) ? GROUP_CH : remaining;
                int unsigned nb  = gch * WT_DW / HBM_DW;
                logic [HBM_DW-1:0] d;
                remaining -= gch;
                for (int unsigned b = 0; b < nb; b++) begin
                    d = rand_beat();
                    q_in.push_back(d);
                    q_wt.push_back('{d: d, gl: (b == nb - 1),
                                     rl: (b == nb - 1) && (remaining == 0)});
                end
                d = rand_beat();
                q_in.push_back(d);
                q_sc.push_back('{d: d, cnt: (gch + QBLOCK - 1) / QBLOCK});
            end
        end
    endtask

    // mode 0: always ready; 1: random 30% backpressure and input gaps;
    // 2: wt_ready low for the first 7 cycles; 3: in_valid held high throughout.
    task automatic run(input string name, input int unsigned chin, input int unsigned rows,
                       input int unsigned mode, input int unsigned abuse_cyc,
                       output int unsigned done_cyc, output bit saw_rdy);
        int unsigned in_cnt   = 0;
        int unsigned done_cnt = 0;
        int unsigned cyc      = 0;
        int unsigned bpg      = GROUP_CH * WT_DW / HBM_DW;
        int unsigned n_full   = chin / GROUP_CH;
        int unsigned last_ch  = chin % GROUP_CH;
        int unsigned exp_beats;
        bit          fin      = 1'b0;
        bit          saw_busy = 1'b0;
        wt_exp_t     we;
        sc_exp_t     se;

        done_cyc  = 0;
        saw_rdy   = 1'b0;
        exp_beats = rows * (n_full * (bpg + 1) +
                            ((last_ch != 0) ? (last_ch * WT_DW / HBM_DW + 1) : 0));
        build_model(chin, rows);

        @(negedge clk);
        cfg_chin = CFG_W'(chin);
        cfg_rows = CFG_W'(rows);
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);

        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = (abuse_cyc != 0) && (cyc == abuse_cyc);
            if (start) begin
                cfg_rows = CFG_W'(rows + 3);
                cfg_chin = CFG_W'(chin + GROUP_CH);
            end
            if (q_in.size() > 0) begin
                in_valid = (mode == 1) ? ($urandom_range(0, 9) < 8) : 1'b1;
                in_data  = q_in[0];
            end else begin
                in_valid = (mode == 3);
                in_data  = '0;
            end
            wt_ready    = (mode == 1) ? ($urandom_range(0, 9) >= 3) :
                          (mode == 2) ? (cyc > 7) : 1'b1;
            scale_ready = (mode == 1) ? ($urandom_range(0, 9) >= 3) : 1'b1;
            #1;
            if (busy) saw_busy = 1'b1;
            if (in_ready) saw_rdy = 1'b1;
            if (wt_valid && wt_ready) begin
                if (q_wt.size() == 0) check_val({name, "/wt_extra"}, wt_valid, 0);
                else begin
                    we = q_wt.pop_front();
                    check_val({name, "/wt_data"}, wt_data, we.d);
                    check_val({name, "/wt_last"}, {wt_group_last, wt_row_last}, {we.gl, we.rl});
                end
            end
            if (scale_valid && scale_ready) begin
                if (q_sc.size() == 0) check_val({name, "/sc_extra"}, scale_valid, 0);
                else begin
                    se = q_sc.pop_front();
                    check_val({name, "/sc_data"}, scale_data, se.d);
                    check_val({name, "/sc_cnt"}, scale_cnt, se.cnt);
                end
            end
            if (in_valid && in_ready) begin
                if (q_in.size() == 0) check_val({name, "/in_extra"}, in_ready, 0);
                else begin
                    void'(q_in.pop_front());
                    in_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                fin      = 1'b1;
            end
        end

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            #1;
            if (done) done_cnt++;
        end

        check_val({name, "/done_once"}, done_cnt, 1);
        check_val({name, "/in_beats"}, in_cnt, exp_beats);
        check_val({name, "/wt_left"}, q_wt.size(), 0);
        check_val({name, "/sc_left"}, q_sc.size(), 0);
        check_val({name, "/busy_seen"}, saw_busy, 1);
        check_val({name, "/busy_end"}, busy, 0);
    endtask

    task automatic reset_midstream();
        int unsigned in_cnt = 0;
        int unsigned cyc    = 0;
        int unsigned dones  = 0;
        build_model(2048, 1);
        @(negedge clk);
        cfg_chin = 16'd2048;
        cfg_rows = 16'd1;
        start    = 1'b1;
        @(posedge clk);
        while (in_cnt < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start       = 1'b0;
            in_valid    = 1'b1;
            in_data     = q_in[0];
            wt_ready    = 1'b1;
            scale_ready = 1'b1;
            #1;
            if (in_valid && in_ready) begin
                void'(q_in.pop_front());
                in_cnt++;
            end
        end
        check_val("rstmid/beats_before", in_cnt, 10);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rstmid/ctrl_outs",
                  {busy, done, in_ready, wt_valid, wt_group_last, wt_row_last, scale_valid, scale_cnt}, 0);
        check_val("rstmid/wt_data", wt_data, 0);
        check_val("rstmid/scale_data", scale_data, 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (done) dones++;
        end
        check_val("rstmid/no_done", dones, 0);
    endtask

    initial begin
        int unsigned dcyc;
        bit          srdy;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset/ctrl_outs",
                  {busy, done, in_ready, wt_valid, scale_valid, scale_cnt}, 0);
        check_val("reset/scale_data", scale_data, 0);
        @(negedge clk);
        rst = 1'b0;

        run("full",      4096, 2, 0, 0, dcyc, srdy);
        run("partial",   2304, 1, 0, 0, dcyc, srdy);
        run("bp_full",   4096, 2, 1, 0, dcyc, srdy);
        run("bp_part",   2304, 3, 1, 0, dcyc, srdy);
        run("bp_small",   320, 2, 1, 0, dcyc, srdy);
        run("restart_busy", 4096, 1, 0, 5, dcyc, srdy);

        run("rows0", 2048, 0, 3, 0, dcyc, srdy);
        check_val("rows0/done_cyc", dcyc, 2);
        check_val("rows0/in_ready", srdy, 0);
        run("chin0", 0, 1, 3, 0, dcyc, srdy);
        check_val("chin0/done_cyc", dcyc, 2);
        check_val("chin0/in_ready", srdy, 0);

        reset_midstream();
        run("after_rst", 2048, 1, 0, 0, dcyc, srdy);

        run("stall7", 2048, 1, 2, 0, dcyc, srdy);
`ifdef WT_STALL_PERF_EN
        check_val("stall7/perf_stall", perf_stall, 7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
